// File: rtl/clk_adc_pwm_gen.sv
// clk_adc_pwm_gen: multi-channel PWM/strobe generator sharing one period counter, with shadowed reloads.
// Define CLK_ADC_PWM_COMPLEMENT_EN to build registered complementary outputs on pwm_n_out.
module clk_adc_pwm_gen #(
  parameter int N_CH = 4,
  parameter int CNT_W = 13,
  parameter int DEF_PERIOD = 50
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  en,
  input  logic                  load,
  input  logic [CNT_W-1:0]      period_in,
  input  logic [N_CH*CNT_W-1:0] duty_in,
  output logic                  load_ack,
  output logic                  tick,
  output logic [N_CH-1:0]       pwm_out,
  output logic [N_CH-1:0]       pwm_n_out
);
  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_PERIOD / 2);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, period_r, period_nx, period_sh, eff;
  logic [N_CH*CNT_W-1:0] duty_r, duty_nx, duty_sh;
  logic [N_CH-1:0] pwm_nx;
  logic pend, wrap, apply;
  // Outputs are registered from next-cycle values so they line up with cnt.
  always_comb begin
    eff = period_r == '0 ? CNT_W'(1) : period_r;
    wrap = state == RUN && cnt == eff - CNT_W'(1);
    apply = pend && (state == IDLE || (en && wrap));
    state_nx = en ? RUN : IDLE;
    cnt_nx = (en && state == RUN && !wrap) ? cnt + CNT_W'(1) : '0;
    period_nx = apply ? period_sh : period_r;
    duty_nx = apply ? duty_sh : duty_r;
    pwm_nx = '0;
    for (int i = 0; i < N_CH; i++) pwm_nx[i] = en && cnt_nx < duty_nx[i*CNT_W +: CNT_W];
  end
  always_ff @(posedge clk) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      period_r <= DEF_P;
      duty_r <= {N_CH{DEF_D}};
      period_sh <= DEF_P;
      duty_sh <= {N_CH{DEF_D}};
      pend <= 1'b0;
      load_ack <= 1'b0;
      tick <= 1'b0;
      pwm_out <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      period_r <= period_nx;
      duty_r <= duty_nx;
      pend <= load || (pend && !apply);
      if (load) begin
        period_sh <= period_in;
        duty_sh <= duty_in;
      end
      load_ack <= apply;
      tick <= en && cnt_nx == '0;
      pwm_out <= pwm_nx;
    end
  end
`ifdef CLK_ADC_PWM_COMPLEMENT_EN
  always_ff @(posedge clk) pwm_n_out <= (RST || !en) ? '0 : ~pwm_nx;
`else
  assign pwm_n_out = '0;
`endif
endmodule

// File: tb/tb_clk_adc_pwm_gen.sv
// tb_clk_adc_pwm_gen: randomized and directed checks of clk_adc_pwm_gen against a period/phase model.
module tb_clk_adc_pwm_gen;
  localparam int N = 4;
  localparam int W = 13;
  localparam int DEF = 50;
  logic clk = 1'b0, RST = 1'b1, en = 1'b0, load = 1'b0;
  logic [W-1:0] period_in = '0;
  logic [N*W-1:0] duty_in = '0;
  logic load_ack, tick;
  logic [N-1:0] pwm_out, pwm_n_out;
  int total = 0, bad = 0;
  bit chk_on = 0;
  clk_adc_pwm_gen #(.N_CH(N), .CNT_W(W), .DEF_PERIOD(DEF)) dut (
    .clk(clk), .RST(RST), .en(en), .load(load), .period_in(period_in), .duty_in(duty_in),
    .load_ack(load_ack), .tick(tick), .pwm_out(pwm_out), .pwm_n_out(pwm_n_out)
  );
  always #5 clk = ~clk;
  // Model: phase within the active period, plus a pending shadow set.
  bit m_run, m_pend, at_end;
  int m_ph, m_per, s_per, eff;
  int m_duty[N], s_duty[N];
  logic e_ack, e_tick;
  logic [N-1:0] e_pwm, e_pwmn;
  always @(posedge clk) begin
    if (RST) begin
      m_run = 0; m_ph = 0; m_per = DEF; m_pend = 0;
      for (int i = 0; i < N; i++) m_duty[i] = DEF / 2;
      e_ack = 0; e_tick = 0; e_pwm = '0; e_pwmn = '0;
    end else begin
      eff = m_per == 0 ? 1 : m_per;
      at_end = m_run && ((m_ph + 1) % eff == 0);
      e_ack = m_pend && (!m_run || (en && at_end));
      m_ph = (en && m_run) ? (m_ph + 1) % eff : 0;
      m_run = en;
      if (e_ack) begin
        m_per = s_per; m_duty = s_duty; m_pend = 0;
      end
      if (load) begin
        s_per = int'(period_in);
        for (int i = 0; i < N; i++) s_duty[i] = int'(duty_in[i*W +: W]);
        m_pend = 1;
      end
      e_tick = m_run && m_ph == 0;
      for (int i = 0; i < N; i++) e_pwm[i] = m_run && m_ph < m_duty[i];
`ifdef CLK_ADC_PWM_COMPLEMENT_EN
      e_pwmn = m_run ? ~e_pwm : '0;
`else
      e_pwmn = '0;
`endif
    end
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (chk_on) check("cycle", {load_ack, tick, pwm_out, pwm_n_out}, {e_ack, e_tick, e_pwm, e_pwmn});
  task automatic do_load(input int p, input int d0, input int d1, input int d2, input int d3);
    load = 1'b1;
    period_in = W'(p);
    duty_in = {W'(d3), W'(d2), W'(d1), W'(d0)};
    @(negedge clk);
    load = 1'b0;
  endtask
  task automatic wait_ack(input int lim);
    int n = 0;
    while (!load_ack && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("ack_wait", load_ack, 1);
  endtask
  initial begin
    int nt, np0, np1, np2, np3, na;
    int tp[$];
    repeat (3) @(negedge clk);
    chk_on = 1;
    RST = 1'b0;
    @(negedge clk);
    check("rst_out", {load_ack, tick, pwm_out, pwm_n_out}, 0);
    en = 1'b1;
    nt = 0; np0 = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) check("first_tick", {tick, pwm_out}, 5'h1F);
      nt += tick; np0 += pwm_out[0];
    end
    check("def_ticks", nt, 2);
    check("def_high", np0, 50);
    repeat (10) @(negedge clk);
    do_load(10, 0, 3, 10, 12);
    wait_ack(60);
    check("ack_tick", tick, 1);
    nt = 0; np0 = 0; np1 = 0; np2 = 0; np3 = 0;
    for (int i = 0; i < 20; i++) begin
      nt += tick; np0 += pwm_out[0]; np1 += pwm_out[1]; np2 += pwm_out[2]; np3 += pwm_out[3];
      @(negedge clk);
    end
    check("p10_ticks", nt, 2);
    check("p10_ch0", np0, 0);
    check("p10_ch1", np1, 6);
    check("p10_ch2", np2, 20);
    check("p10_ch3", np3, 20);
    repeat (3) @(negedge clk);
    do_load(0, 5, 0, 1, 2);
    wait_ack(30);
    nt = 0; np0 = 0; np1 = 0;
    for (int i = 0; i < 10; i++) begin
      nt += tick; np0 += (pwm_out == 4'b1101);
      @(negedge clk);
    end
    check("p0_ticks", nt, 10);
    check("p0_pwm", np0, 10);
    do_load(30, 15, 15, 15, 15);
    wait_ack(5);
    do_load(8, 2, 2, 2, 2);
    repeat (2) @(negedge clk);
    do_load(20, 5, 5, 5, 5);
    na = 0;
    for (int i = 0; i < 60; i++) begin
      na += load_ack;
      if (tick) tp.push_back(i);
      @(negedge clk);
    end
    check("dbl_acks", na, 1);
    check("dbl_len", tp.size() >= 2 ? tp[1] - tp[0] : -1, 20);
    do_load(10, 4, 4, 4, 4);
    wait_ack(40);
    repeat (5) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_out", {tick, pwm_out, pwm_n_out}, 0);
    end
    en = 1'b1;
    @(negedge clk);
    check("restart", {tick, pwm_out}, 5'h1F);
    for (int i = 0; i < 3000; i++) begin
      RST = $urandom_range(99) == 0;
      en = $urandom_range(9) != 0;
      load = $urandom_range(9) == 0;
      period_in = W'($urandom_range(12));
      for (int c = 0; c < N; c++) duty_in[c*W +: W] = W'($urandom_range(14));
      @(negedge clk);
    end
    RST = 1'b0; load = 1'b0; en = 1'b0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
